// File: rtl/timer.sv
// Programmable up-counting timer with a CPU-style strobe bus.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   cs_      chip select, active low
//   as_      address strobe, active low
//   rw       1 = read, 0 = write
//   addr     register select: 0 CTRL, 1 INTR, 2 EXPR, 3 COUNTER
//   wr_data  write data
//   rd_data  read data, valid while rdy_ = 0, zero otherwise
//   rdy_     ready, active low, asserted the cycle after each access
//   irq      level interrupt, mirrors the INTR flag
//
// Register map:
//   CTRL    bit0 start, bit1 periodic (other bits read 0)
//   INTR    bit0 flag (other bits read 0)
//   EXPR    32-bit expiration value
//   COUNTER 32-bit up-counter
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_INTR    = 2'd1,
    REG_EXPR    = 2'd2,
    REG_COUNTER = 2'd3
  } reg_sel_e;

  logic        start_q;
  logic        periodic_q;
  logic        flag_q;
  logic [31:0] expr_q;
  logic [31:0] counter_q;

  logic        start_d;
  logic        periodic_d;
  logic        flag_d;
  logic [31:0] expr_d;
  logic [31:0] counter_d;

  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic        expire;
  reg_sel_e    sel;
  logic [31:0] rd_mux;

  assign access = ~cs_ & ~as_;
  assign wr_en  = access & ~rw;
  assign rd_en  = access & rw;
  assign sel    = reg_sel_e'(addr);
  assign expire = start_q && (counter_q == expr_q);

  // Priority (lowest to highest): hold/increment, expiry effects, bus write.
  // The INTR write is OR-ed with expiry so a same-cycle clear cannot lose an
  // interrupt.
  always_comb begin
    start_d    = start_q;
    periodic_d = periodic_q;
    flag_d     = flag_q;
    expr_d     = expr_q;
    counter_d  = counter_q;

    if (start_q) begin
      counter_d = counter_q + 32'd1;
    end

    if (expire) begin
      flag_d    = 1'b1;
      counter_d = '0;
      if (!periodic_q) begin
        start_d = 1'b0;
      end
    end

    if (wr_en) begin
      case (sel)
        REG_CTRL: begin
          start_d    = wr_data[0];
          periodic_d = wr_data[1];
        end
        REG_INTR:    flag_d    = wr_data[0] | expire;
        REG_EXPR:    expr_d    = wr_data;
        REG_COUNTER: counter_d = wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:    rd_mux = {30'd0, periodic_q, start_q};
      REG_INTR:    rd_mux = {31'd0, flag_q};
      REG_EXPR:    rd_mux = expr_q;
      REG_COUNTER: rd_mux = counter_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      flag_q     <= 1'b0;
      expr_q     <= '0;
      counter_q  <= '0;
      rdy_       <= 1'b1;
      rd_data    <= '0;
    end else begin
      start_q    <= start_d;
      periodic_q <= periodic_d;
      flag_q     <= flag_d;
      expr_q     <= expr_d;
      counter_q  <= counter_d;
      rdy_       <= ~access;
      rd_data    <= rd_en ? rd_mux : '0;
    end
  end

  assign irq = flag_q;

endmodule

// File: tb/tb_timer.sv
// Directed testbench for the timer block.
module tb_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_INTR = 2'd1;
  localparam logic [1:0] A_EXPR = 2'd2;
  localparam logic [1:0] A_CNT  = 2'd3;

  timer dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // All stimulus changes at 1ns after a rising edge; outputs are sampled there too.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d, output logic r);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    @(posedge clk);
    #1;
    d = rd_data;
    r = rdy_;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    reset = 1'b1;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = A_CTRL;  // access discarded by reset
    idle_cycles(2);
    ntests++; if (rdy_ !== 1'b1) begin nfail++; $display("FAIL reset_rdy: got %b expected 1", rdy_); end
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    ntests++; if (rd_data !== 32'd0) begin nfail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    cs_ = 1'b1; as_ = 1'b1;
    reset = 1'b0;
    idle_cycles(1);
    ntests++; if (rdy_ !== 1'b1) begin nfail++; $display("FAIL idle_rdy: got %b expected 1", rdy_); end
    ntests++; if (rd_data !== 32'd0) begin nfail++; $display("FAIL idle_rd_data: got %h expected 0", rd_data); end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), d, r);
      ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL reset_read_%0d: got %h expected 0", i, d); end
      ntests++; if (r !== 1'b0) begin nfail++; $display("FAIL reset_read_rdy_%0d: got %b expected 0", i, r); end
    end
    // back-to-back reads above end here; response must drop after one cycle
    idle_cycles(1);
    ntests++; if (rdy_ !== 1'b1) begin nfail++; $display("FAIL rdy_release: got %b expected 1", rdy_); end
  endtask

  task automatic test_unused_bits();
    logic [31:0] d;
    logic        r;
    write_reg(A_CTRL, 32'hFFFF_FFFC);
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL ctrl_unused: got %h expected 0", d); end
    write_reg(A_INTR, 32'hFFFF_FFFE);
    read_reg(A_INTR, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL intr_unused: got %h expected 0", d); end
    write_reg(A_EXPR, 32'hA5A5_1234);
    read_reg(A_EXPR, d, r);
    ntests++; if (d !== 32'hA5A5_1234) begin nfail++; $display("FAIL expr_rw: got %h expected a5a51234", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        r;
    write_reg(A_EXPR, 32'd5);
    write_reg(A_CTRL, 32'h1);
    for (int i = 0; i <= 5; i++) begin
      read_reg(A_CNT, d, r);
      ntests++; if (d !== 32'(i)) begin nfail++; $display("FAIL oneshot_count_%0d: got %h expected %h", i, d, 32'(i)); end
      if (i < 5) begin
        ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL oneshot_irq_early_%0d: got %b expected 0", i, irq); end
      end
    end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL oneshot_ctrl: got %h expected 0", d); end
    idle_cycles(3);
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL oneshot_hold: got %h expected 0", d); end
    read_reg(A_INTR, d, r);
    ntests++; if (d !== 32'd1) begin nfail++; $display("FAIL oneshot_flag: got %h expected 1", d); end
    write_reg(A_INTR, 32'd0);
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL oneshot_clear: got %b expected 0", irq); end
  endtask

  task automatic test_periodic_and_reset();
    logic [31:0] d;
    logic        r;
    write_reg(A_EXPR, 32'd3);
    write_reg(A_CTRL, 32'h3);
    for (int i = 0; i < 3; i++) begin
      idle_cycles(1);
      ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL periodic_irq_pre_%0d: got %b expected 0", i, irq); end
    end
    idle_cycles(1);
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL periodic_irq_1: got %b expected 1", irq); end
    write_reg(A_INTR, 32'd0);
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL periodic_clear: got %b expected 0", irq); end
    idle_cycles(2);
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL periodic_irq_gap: got %b expected 0", irq); end
    idle_cycles(1);
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL periodic_irq_2: got %b expected 1", irq); end
    write_reg(A_INTR, 32'd0);
    idle_cycles(2);
    // this write lands on the expiry edge; expiry must win
    write_reg(A_INTR, 32'd0);
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL clear_vs_expiry: got %b expected 1", irq); end
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd3) begin nfail++; $display("FAIL periodic_ctrl: got %h expected 3", d); end

    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL midrun_reset_irq: got %b expected 0", irq); end
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL midrun_reset_ctrl: got %h expected 0", d); end
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL midrun_reset_cnt: got %h expected 0", d); end
    idle_cycles(20);
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL midrun_reset_hold: got %h expected 0", d); end
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL midrun_reset_irq_hold: got %b expected 0", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        r;
    logic [31:0] exp_seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    write_reg(A_CNT, 32'hFFFF_FFFE);
    write_reg(A_EXPR, 32'd1);
    write_reg(A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      read_reg(A_CNT, d, r);
      ntests++; if (d !== exp_seq[i]) begin nfail++; $display("FAIL wrap_count_%0d: got %h expected %h", i, d, exp_seq[i]); end
    end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL wrap_irq: got %b expected 1", irq); end
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL wrap_after: got %h expected 0", d); end
  endtask

  task automatic test_expr_zero();
    logic [31:0] d;
    logic        r;
    write_reg(A_INTR, 32'd0);
    write_reg(A_EXPR, 32'd0);
    write_reg(A_CTRL, 32'h3);
    for (int i = 0; i < 3; i++) begin
      read_reg(A_CNT, d, r);
      ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL expr0_count_%0d: got %h expected 0", i, d); end
    end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL expr0_irq: got %b expected 1", irq); end
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd3) begin nfail++; $display("FAIL expr0_ctrl: got %h expected 3", d); end
    write_reg(A_CTRL, 32'h0);
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    logic        r;
    // COUNTER write on the expiry edge beats the expiry reset
    write_reg(A_INTR, 32'd0);
    write_reg(A_CNT, 32'd0);
    write_reg(A_EXPR, 32'd2);
    write_reg(A_CTRL, 32'h1);
    idle_cycles(2);
    write_reg(A_CNT, 32'd10);
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd10) begin nfail++; $display("FAIL cnt_write_vs_expiry: got %h expected a", d); end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL cnt_write_expiry_irq: got %b expected 1", irq); end
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd0) begin nfail++; $display("FAIL cnt_write_oneshot_ctrl: got %h expected 0", d); end

    // CTRL write on the expiry edge beats the one-shot stop
    write_reg(A_INTR, 32'd0);
    write_reg(A_CNT, 32'd0);
    write_reg(A_CTRL, 32'h1);
    idle_cycles(2);
    write_reg(A_CTRL, 32'h1);
    read_reg(A_CTRL, d, r);
    ntests++; if (d !== 32'd1) begin nfail++; $display("FAIL ctrl_write_vs_expiry: got %h expected 1", d); end
    read_reg(A_CNT, d, r);
    ntests++; if (d !== 32'd1) begin nfail++; $display("FAIL ctrl_write_count: got %h expected 1", d); end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL ctrl_write_irq: got %b expected 1", irq); end
    write_reg(A_CTRL, 32'h0);
  endtask

  initial begin
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_unused_bits();
    test_oneshot();
    test_periodic_and_reset();
    test_wrap();
    test_expr_zero();
    test_collisions();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
